// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: hsync/vsync/de/x/y from a pixel clock-enable.
// Optional VTG_LOOKAHEAD_EN delays the sync/enable outputs so x/y lead them by LOOKAHEAD pixels.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int LOOKAHEAD = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ce,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start,
    output logic [7:0]     frame_cnt
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    if ((LOOKAHEAD < 1) || (LOOKAHEAD > 4)) begin : g_lookahead_range_bad
        $error("LOOKAHEAD must be within 1..4");
    end

    logic [X_W-1:0] r_h;
    logic [Y_W-1:0] r_v;
    logic           w_h_last;
    logic           w_v_last;

    assign w_h_last = (r_h == X_W'(H_TOTAL - 1));
    assign w_v_last = (r_v == Y_W'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (ce) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // One extra bit so bounds equal to the total never truncate.
    logic [X_W:0] w_h_ext;
    logic [Y_W:0] w_v_ext;
    logic         w_de;
    logic         w_hs_act;
    logic         w_vs_act;
    logic         w_ls;
    logic         w_fs;

    assign w_h_ext  = {1'b0, r_h};
    assign w_v_ext  = {1'b0, r_v};
    assign w_de     = (w_h_ext < (X_W+1)'(H_ACTIVE)) && (w_v_ext < (Y_W+1)'(V_ACTIVE));
    assign w_hs_act = (w_h_ext >= (X_W+1)'(HS_START)) && (w_h_ext < (X_W+1)'(HS_END));
    assign w_vs_act = (w_v_ext >= (Y_W+1)'(VS_START)) && (w_v_ext < (Y_W+1)'(VS_END));
    assign w_ls     = (r_h == '0) && (w_v_ext < (Y_W+1)'(V_ACTIVE));
    assign w_fs     = (r_h == '0) && (r_v == '0);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           r_hsync;
    logic           r_vsync;
    logic           r_de;
    logic           r_ls;
    logic           r_fs;
    logic [7:0]     r_fc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_de    <= 1'b0;
            r_ls    <= 1'b0;
            r_fs    <= 1'b0;
            r_fc    <= '0;
        end else if (ce) begin
            r_x     <= r_h;
            r_y     <= r_v;
            r_hsync <= w_hs_act ? H_POL : ~H_POL;
            r_vsync <= w_vs_act ? V_POL : ~V_POL;
            r_de    <= w_de;
            r_ls    <= w_ls;
            r_fs    <= w_fs;
            if (w_fs) begin
                r_fc <= r_fc + 8'd1;
            end
        end
    end

    assign x = r_x;
    assign y = r_y;

`ifdef VTG_LOOKAHEAD_EN
    localparam logic [12:0] STAGE_RST = {~H_POL, ~V_POL, 11'd0};

    logic [12:0] w_stage [LOOKAHEAD+1];

    assign w_stage[0] = {r_hsync, r_vsync, r_de, r_ls, r_fs, r_fc};

    for (genvar gi = 0; gi < LOOKAHEAD; gi++) begin : g_lookahead
        logic [12:0] r_stage;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_stage <= STAGE_RST;
            end else if (ce) begin
                r_stage <= w_stage[gi];
            end
        end
        assign w_stage[gi+1] = r_stage;
    end

    assign {hsync, vsync, de, line_start, frame_start, frame_cnt} = w_stage[LOOKAHEAD];
`else
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
    assign frame_cnt   = r_fc;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a tiny positive-polarity raster (8x6) plus the default 640x480 raster for its first lines.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic reset;
    logic ce;

    always #5 clk = ~clk;

    logic       p_hs, p_vs, p_de, p_ls, p_fs;
    logic [2:0] p_x, p_y;
    logic [7:0] p_fc;

    logic       n_hs, n_vs, n_de, n_ls, n_fs;
    logic [9:0] n_x, n_y;
    logic [7:0] n_fc;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .X_W(3), .Y_W(3), .LOOKAHEAD(2)
    ) u_pos (
        .clk(clk), .reset(reset), .ce(ce),
        .hsync(p_hs), .vsync(p_vs), .de(p_de), .x(p_x), .y(p_y),
        .line_start(p_ls), .frame_start(p_fs), .frame_cnt(p_fc)
    );

    vga_timing_gen u_neg (
        .clk(clk), .reset(reset), .ce(ce),
        .hsync(n_hs), .vsync(n_vs), .de(n_de), .x(n_x), .y(n_y),
        .line_start(n_ls), .frame_start(n_fs), .frame_cnt(n_fc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int hs_p = 0, vs_p = 0, de_p = 0, fs_p = 0, ls_p = 0, bad_p = 0, per_bad = 0, last_fs = -1;
        int hs_n = 0, de_n = 0, bad_n = 0;
        logic [2:0] px, py;
        logic bnd_done = 1'b0;
        logic prev_fs, found;
        int r1 = -1, r2 = -1, w1 = -1, wcnt = 0;
        logic [7:0] fc1 = 8'd0, fc2 = 8'd0;

        reset = 1'b0;
        ce    = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_x", p_x, 0);
        check_val("rst_y", p_y, 0);
        check_val("rst_de", p_de, 0);
        check_val("rst_hs_pos", p_hs, 0);
        check_val("rst_vs_pos", p_vs, 0);
        check_val("rst_fs", p_fs, 0);
        check_val("rst_ls", p_ls, 0);
        check_val("rst_fc", p_fc, 0);
        check_val("rst_hs_neg", n_hs, 1);
        check_val("rst_vs_neg", n_vs, 1);

        reset = 1'b1;
        ce    = 1'b1;
        for (int i = 0; i < 800; i++) begin
            px = p_x;
            py = p_y;
            step();
            if (i == 0) begin
                check_val("first_x", p_x, 0);
                check_val("first_y", p_y, 0);
                check_val("first_de", p_de, 1);
                check_val("first_fs", p_fs, 1);
                check_val("first_ls", p_ls, 1);
                check_val("first_fc", p_fc, 1);
                check_val("first_hs_neg", n_hs, 1);
            end
            if (!bnd_done && px == 3'd7 && py == 3'd5) begin
                bnd_done = 1'b1;
                check_val("wrap_vs", p_vs, 0);
                check_val("wrap_de", p_de, 1);
                check_val("wrap_fs", p_fs, 1);
                check_val("wrap_ls", p_ls, 1);
            end
            if (p_hs) begin
                hs_p++;
                if (p_x < 3'd5 || p_x > 3'd6 || p_de) bad_p++;
            end
            if (p_vs) begin
                vs_p++;
                if (p_y != 3'd4 || p_de) bad_p++;
            end
            if (p_de) begin
                de_p++;
                if (p_x > 3'd3 || p_y > 3'd2) bad_p++;
            end
            if (p_fs) begin
                fs_p++;
                if (last_fs >= 0 && i - last_fs != 48) per_bad++;
                last_fs = i;
                if (p_x != 0 || p_y != 0) bad_p++;
            end
            if (p_ls) ls_p++;
            if (!n_hs) begin
                hs_n++;
                if (n_x < 10'd656 || n_x > 10'd751) bad_n++;
            end
            if (n_de) de_n++;
            if (!n_vs || n_x != 10'(i) || n_y != 10'd0) bad_n++;
        end
        check_val("wrap_seen", bnd_done, 1);
        check_val("pos_hs_edges", hs_p, 200);
        check_val("pos_vs_edges", vs_p, 128);
        check_val("pos_de_edges", de_p, 204);
        check_val("pos_fs_count", fs_p, 17);
        check_val("pos_ls_count", ls_p, 51);
        check_val("pos_decode_bad", bad_p, 0);
        check_val("pos_fs_period_bad", per_bad, 0);
        check_val("pos_fc", p_fc, 17);
        check_val("neg_hs_low_edges", hs_n, 96);
        check_val("neg_de_edges", de_n, 640);
        check_val("neg_line0_bad", bad_n, 0);

        step();
        check_val("neg_l1_x", n_x, 0);
        check_val("neg_l1_y", n_y, 1);
        check_val("neg_l1_ls", n_ls, 1);
        check_val("neg_l1_fs", n_fs, 0);
        check_val("pos_v4_y", p_y, 4);
        check_val("pos_v4_vs", p_vs, 1);

        prev_fs = p_fs;
        for (int i = 0; i < 300; i++) begin
            ce = (i % 2 == 0);
            step();
            if (p_fs && !prev_fs) begin
                if (r1 < 0) begin
                    r1 = i;
                    fc1 = p_fc;
                end else if (r2 < 0) begin
                    r2 = i;
                    fc2 = p_fc;
                end
            end
            if (p_fs) wcnt++;
            if (!p_fs && prev_fs && w1 < 0) w1 = wcnt;
            prev_fs = p_fs;
        end
        check_val("ce_fs_width", w1, 2);
        check_val("ce_fs_period", r2 - r1, 96);
        check_val("ce_fc_incr", 8'(fc2 - fc1), 1);

        ce = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (p_x == 3'd2 && p_y == 3'd1) found = 1'b1;
        end
        check_val("seek_2_1", found, 1);
        check_val("pre_rst_de", p_de, 1);
        #2 reset = 1'b0;
        #1;
        check_val("arst_x", p_x, 0);
        check_val("arst_y", p_y, 0);
        check_val("arst_de", p_de, 0);
        check_val("arst_hs", p_hs, 0);
        check_val("arst_fc", p_fc, 0);
        check_val("arst_hs_neg", n_hs, 1);
        check_val("arst_vs_neg", n_vs, 1);

        @(negedge clk);
        ce    = 1'b0;
        reset = 1'b1;
        step();
        check_val("rel_ce0_fs", p_fs, 0);
        check_val("rel_ce0_de", p_de, 0);
        ce = 1'b1;
        step();
        check_val("rel_x", p_x, 0);
        check_val("rel_y", p_y, 0);
        check_val("rel_fs", p_fs, 1);
        check_val("rel_fc", p_fc, 1);
        check_val("rel_de", p_de, 1);

        repeat (255 * 48 - 1) step();
        check_val("fc255", p_fc, 255);
        check_val("fc255_x", p_x, 7);
        check_val("fc255_y", p_y, 5);
        step();
        check_val("fc_wrap", p_fc, 0);
        check_val("fc_wrap_fs", p_fs, 1);
        check_val("fc_wrap_x", p_x, 0);
        check_val("fc_wrap_de", p_de, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
